// File: rtl/csi_div_sched.sv
// Purpose: shares one complex divider between the channel-estimate (port 0) and pilot-tracking (port 1) requesters.
// Latency: accepted request -> div_strobe next cycle; div_out_strobe -> res_valid next cycle.
// Backpressure: ready is withheld while MAX_INFLIGHT operations are outstanding; the result side has no backpressure.
module csi_div_sched #(
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,

  input  logic [15:0]       req0_a_i,
  input  logic [15:0]       req0_a_q,
  input  logic [15:0]       req0_b_i,
  input  logic [15:0]       req0_b_q,
  input  logic              req0_valid,
  output logic              req0_ready,

  input  logic [15:0]       req1_a_i,
  input  logic [15:0]       req1_a_q,
  input  logic [15:0]       req1_b_i,
  input  logic [15:0]       req1_b_q,
  input  logic              req1_valid,
  output logic              req1_ready,

  output logic [15:0]       div_a_i,
  output logic [15:0]       div_a_q,
  output logic [15:0]       div_b_i,
  output logic [15:0]       div_b_q,
  output logic              div_strobe,
  input  logic [31:0]       div_p_i,
  input  logic [31:0]       div_p_q,
  input  logic              div_out_strobe,

  output logic [31:0]       res_p_i,
  output logic [31:0]       res_p_q,
  output logic              res_src,
  output logic              res_div0,
  output logic              res_valid,

  output logic [CNT_W-1:0]  inflight,
  output logic              err_orphan,
  output logic              err_overflow
);

  // Pointers wrap naturally because the depth is a power of two.
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  // Round-robin pointer: 0 favours port 0 when both request, 1 favours port 1.
  logic              rr_ptr;
  logic              grant0;
  logic              grant1;
  logic              credit_ok;
  logic              xfer0;
  logic              xfer1;
  logic              push;
  logic              pop;
  logic              orphan;
  logic              fifo_empty;

  // Operands of the request being accepted this cycle.
  logic [15:0]       sel_a_i;
  logic [15:0]       sel_a_q;
  logic [15:0]       sel_b_i;
  logic [15:0]       sel_b_q;
  logic              sel_div0;

  // In-order tag store: bit 1 = source port, bit 0 = zero divisor.
  logic [1:0]        tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [1:0]        head_tag;

  // Credit check uses only the registered count, so a pop frees a slot one cycle later.
  assign credit_ok  = (inflight < MAX_CNT);
  assign fifo_empty = (inflight == '0);

  // Combinational round-robin grant between the two requesters.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = ~rr_ptr;
      grant1 = rr_ptr;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Reset gates ready directly so nothing is accepted while state is being cleared.
  assign req0_ready = ~reset & enable & credit_ok & grant0;
  assign req1_ready = ~reset & enable & credit_ok & grant1;

  assign xfer0 = req0_valid & req0_ready;
  assign xfer1 = req1_valid & req1_ready;
  assign push  = xfer0 | xfer1;

  // A returning quotient only retires if a tag is waiting for it.
  assign pop    = div_out_strobe & ~fifo_empty;
  assign orphan = div_out_strobe &  fifo_empty;

  assign head_tag = tag_mem[rd_ptr];

  // Select the operands of whichever port transfers this cycle.
  always_comb begin
    sel_a_i = req0_a_i;
    sel_a_q = req0_a_q;
    sel_b_i = req0_b_i;
    sel_b_q = req0_b_q;
    if (xfer1) begin
      sel_a_i = req1_a_i;
      sel_a_q = req1_a_q;
      sel_b_i = req1_b_i;
      sel_b_q = req1_b_q;
    end
    sel_div0 = (sel_b_i == 16'd0) && (sel_b_q == 16'd0);
  end

  // Flip the round-robin pointer away from the port just served.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (push) begin
      rr_ptr <= xfer0;
    end
  end

  // Register operands toward the divider; strobe for exactly one cycle per accepted request.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_a_i    <= '0;
      div_a_q    <= '0;
      div_b_i    <= '0;
      div_b_q    <= '0;
      div_strobe <= 1'b0;
    end else begin
      div_strobe <= push;
      if (push) begin
        div_a_i <= sel_a_i;
        div_a_q <= sel_a_q;
        div_b_i <= sel_b_i;
        div_b_q <= sel_b_q;
      end
    end
  end

  // Tag storage; contents need no reset because the count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      tag_mem[wr_ptr] <= {xfer1, sel_div0};
    end
  end

  // Tag FIFO pointers and the outstanding-operation count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_orphan   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (orphan) begin
        err_orphan <= 1'b1;
      end
      if (push && (inflight == MAX_CNT)) begin
        err_overflow <= 1'b1;
      end
    end
  end

  // Route the returning quotient with the tag of the oldest outstanding operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      res_p_i   <= '0;
      res_p_q   <= '0;
      res_src   <= 1'b0;
      res_div0  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= pop;
      if (pop) begin
        res_p_i  <= div_p_i;
        res_p_q  <= div_p_q;
        res_src  <= head_tag[1];
        res_div0 <= head_tag[0];
      end
    end
  end

endmodule

// File: tb/tb_csi_div_sched.sv
// Bench for csi_div_sched: fixed-latency divider stand-in, scoreboard of issued operations,
// table of single-request vectors, and hand-written sequences for arbitration, credits,
// enable, orphan strobes and mid-flight reset.
module tb_csi_div_sched;

  localparam int L = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] req0_a_i, req0_a_q, req0_b_i, req0_b_q;
  logic        req0_valid, req0_ready;
  logic [15:0] req1_a_i, req1_a_q, req1_b_i, req1_b_q;
  logic        req1_valid, req1_ready;
  logic [15:0] div_a_i, div_a_q, div_b_i, div_b_q;
  logic        div_strobe;
  logic [31:0] div_p_i, div_p_q;
  logic        div_out_strobe;
  logic [31:0] res_p_i, res_p_q;
  logic        res_src, res_div0, res_valid;
  logic [3:0]  inflight;
  logic        err_orphan, err_overflow;

  logic        inj;

  csi_div_sched #(.MAX_INFLIGHT(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .req0_a_i(req0_a_i), .req0_a_q(req0_a_q), .req0_b_i(req0_b_i), .req0_b_q(req0_b_q),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_a_i(req1_a_i), .req1_a_q(req1_a_q), .req1_b_i(req1_b_i), .req1_b_q(req1_b_q),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .div_a_i(div_a_i), .div_a_q(div_a_q), .div_b_i(div_b_i), .div_b_q(div_b_q),
    .div_strobe(div_strobe), .div_p_i(div_p_i), .div_p_q(div_p_q),
    .div_out_strobe(div_out_strobe),
    .res_p_i(res_p_i), .res_p_q(res_p_q), .res_src(res_src), .res_div0(res_div0),
    .res_valid(res_valid), .inflight(inflight),
    .err_orphan(err_orphan), .err_overflow(err_overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Divider stand-in: fixed latency L, packs {a,b} into the quotient so routing is visible.
  logic [L-1:0] dv;
  logic [31:0]  dpi [L];
  logic [31:0]  dpq [L];
  always @(posedge clock) begin
    if (reset) begin
      dv <= '0;
    end else begin
      dv     <= {dv[L-2:0], div_strobe};
      dpi[0] <= {div_a_i, div_b_i};
      dpq[0] <= {div_a_q, div_b_q};
      for (int k = 1; k < L; k++) begin
        dpi[k] <= dpi[k-1];
        dpq[k] <= dpq[k-1];
      end
    end
  end
  assign div_out_strobe = dv[L-1] | inj;
  assign div_p_i        = dpi[L-1];
  assign div_p_q        = dpq[L-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: one entry per accepted request, popped in order on res_valid.
  typedef struct {
    logic        src;
    logic        div0;
    logic [31:0] pi;
    logic [31:0] pq;
    int          tcyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  logic        iss_pend = 1'b0;
  logic [15:0] iss_ai, iss_aq, iss_bi, iss_bq;

  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      iss_pend = 1'b0;
    end else begin
      chk("div_strobe", div_strobe, iss_pend);
      if (iss_pend) begin
        chk("div_a_i", div_a_i, iss_ai);
        chk("div_a_q", div_a_q, iss_aq);
        chk("div_b_i", div_b_i, iss_bi);
        chk("div_b_q", div_b_q, iss_bq);
      end
      chk("one_ready", req0_ready & req1_ready, 0);
      chk("err_overflow", err_overflow, 0);
      chk("inflight_le_max", inflight <= 4'd8, 1);
      if (res_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL res_unexpected: got res_valid=1 required 0 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("res_src", res_src, e.src);
          chk("res_div0", res_div0, e.div0);
          chk("res_p_i", res_p_i, e.pi);
          chk("res_p_q", res_p_q, e.pq);
          chk("res_latency", cyc, e.tcyc + L + 2);
        end
      end
      iss_pend = 1'b0;
      if (req0_valid && req0_ready) begin
        iss_pend = 1'b1;
        iss_ai = req0_a_i; iss_aq = req0_a_q; iss_bi = req0_b_i; iss_bq = req0_b_q;
      end else if (req1_valid && req1_ready) begin
        iss_pend = 1'b1;
        iss_ai = req1_a_i; iss_aq = req1_a_q; iss_bi = req1_b_i; iss_bq = req1_b_q;
      end
      if (iss_pend) begin
        e.src  = req1_valid && req1_ready;
        e.div0 = (iss_bi == 16'd0) && (iss_bq == 16'd0);
        e.pi   = {iss_ai, iss_bi};
        e.pq   = {iss_aq, iss_bq};
        e.tcyc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic set_port(input logic src, input logic [15:0] ai, aq, bi, bq);
    if (!src) begin
      req0_a_i = ai; req0_a_q = aq; req0_b_i = bi; req0_b_q = bq; req0_valid = 1'b1;
    end else begin
      req1_a_i = ai; req1_a_q = aq; req1_b_i = bi; req1_b_q = bq; req1_valid = 1'b1;
    end
  endtask

  // Hold one request until accepted (bounded), then drop valid.
  task automatic issue(input logic src, input logic [15:0] ai, aq, bi, bq);
    bit ok;
    ok = 1'b0;
    @(posedge clock); #1;
    set_port(src, ai, aq, bi, bq);
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clock);
      ok = src ? req1_ready : req0_ready;
    end
    if (!ok) chk("issue_timeout", 0, 1);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_res(output bit got);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clock);
      got = res_valid;
    end
    if (!got) chk("result_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clock);
      done = (inflight == 4'd0) && !res_valid && !div_strobe;
    end
    @(negedge clock);
    chk("drain_done", done, 1);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        src;
    logic [15:0] ai, aq, bi, bq;
    logic        exp_div0;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    bit got;
    int acc, first_res, ninth, n_x, n_r;

    vecs[0] = '{1'b0, 16'd1,    16'd2,    16'd3,    16'd4,    1'b0};
    vecs[1] = '{1'b1, 16'h7fff, 16'h8000, 16'd0,    16'd0,    1'b1};
    vecs[2] = '{1'b1, 16'd5,    16'd6,    16'd0,    16'd1,    1'b0};
    vecs[3] = '{1'b0, 16'd7,    16'd8,    16'd1,    16'd0,    1'b0};
    vecs[4] = '{1'b0, 16'd9,    16'd9,    16'd0,    16'd0,    1'b1};
    vecs[5] = '{1'b1, 16'hffff, 16'd1,    16'hffff, 16'hffff, 1'b0};

    reset = 1'b1; enable = 1'b0; inj = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a_i = '0; req0_a_q = '0; req0_b_i = '0; req0_b_q = '0;
    req1_a_i = '0; req1_a_q = '0; req1_b_i = '0; req1_b_q = '0;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_inflight", inflight, 0);
    chk("rst_div_strobe", div_strobe, 0);
    chk("rst_div_a_i", div_a_i, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_p_i", res_p_i, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_err_overflow", err_overflow, 0);
    @(posedge clock); #1;
    reset = 1'b0; enable = 1'b1;

    // Single port-0 request.
    issue(1'b0, 16'd1000, 16'hff38, 16'd50, 16'd7);
    @(negedge clock);
    chk("single_inflight_1", inflight, 1);
    wait_res(got);
    chk("single_res_src", res_src, 0);
    chk("single_res_div0", res_div0, 0);
    chk("single_res_p_i", res_p_i, {16'd1000, 16'd50});
    chk("single_inflight_0", inflight, 0);

    // Table-driven single requests.
    foreach (vecs[i]) begin
      issue(vecs[i].src, vecs[i].ai, vecs[i].aq, vecs[i].bi, vecs[i].bq);
      wait_res(got);
      chk("vec_res_src", res_src, vecs[i].src);
      chk("vec_res_div0", res_div0, vecs[i].exp_div0);
      chk("vec_res_p_i", res_p_i, {vecs[i].ai, vecs[i].bi});
      chk("vec_res_p_q", res_p_q, {vecs[i].aq, vecs[i].bq});
    end
    drain();

    // Both ports continuously valid: alternating grants starting at port 0 after reset.
    do_reset(2);
    @(posedge clock); #1;
    set_port(1'b0, 16'd11, 16'd12, 16'd13, 16'd14);
    set_port(1'b1, 16'd21, 16'd22, 16'd23, 16'd24);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("rr_grant_port1", req1_ready, k % 2);
      chk("rr_any_grant", req0_ready | req1_ready, 1);
    end
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Port 0 streams 12 back-to-back requests against 8 credits.
    acc = 0; first_res = -1; ninth = -1;
    @(posedge clock); #1;
    set_port(1'b0, 16'd100, 16'd200, 16'd3, 16'd0);
    for (int c = 0; c < 400 && acc < 12; c++) begin
      @(negedge clock);
      if (res_valid && first_res < 0) begin
        first_res = cyc;
        chk("stream_acc_at_first_res", acc, 8);
      end
      if (acc == 8 && first_res < 0) begin
        chk("stream_blocked_ready", req0_ready, 0);
        chk("stream_full_inflight", inflight, 8);
      end
      if (req0_ready) begin
        acc++;
        if (acc == 9) ninth = cyc;
      end
      @(posedge clock); #1;
      if (acc < 12) set_port(1'b0, 16'(100 + acc), 16'(200 + acc), 16'd3, 16'(acc));
      else req0_valid = 1'b0;
    end
    req0_valid = 1'b0;
    chk("stream_accepted", acc, 12);
    chk("stream_credit_return_cycle", ninth, first_res);
    drain();

    // enable=0 with 3 in flight and both ports requesting.
    issue(1'b1, 16'd31, 16'd32, 16'd33, 16'd34);
    issue(1'b1, 16'd35, 16'd36, 16'd37, 16'd38);
    issue(1'b1, 16'd39, 16'd40, 16'd41, 16'd42);
    @(posedge clock); #1;
    enable = 1'b0;
    set_port(1'b0, 16'd1, 16'd1, 16'd1, 16'd1);
    set_port(1'b1, 16'd2, 16'd2, 16'd2, 16'd2);
    n_x = 0; n_r = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (req0_ready || req1_ready) n_x++;
      if (res_valid) n_r++;
    end
    chk("en0_no_issue", n_x, 0);
    chk("en0_results", n_r, 3);
    chk("en0_inflight", inflight, 0);
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; enable = 1'b1;
    drain();

    // Orphan output strobe with nothing outstanding.
    @(posedge clock); #1;
    inj = 1'b1;
    @(posedge clock); #1;
    inj = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("orphan_no_res", res_valid, 0);
      chk("orphan_sticky", err_orphan, 1);
      chk("orphan_inflight", inflight, 0);
    end

    // Reset with 5 operations in flight.
    for (int k = 0; k < 5; k++) issue(1'b0, 16'(50 + k), 16'd1, 16'd2, 16'd3);
    @(negedge clock);
    chk("pre_rst_inflight", inflight, 5);
    @(posedge clock); #1;
    reset = 1'b1;
    set_port(1'b0, 16'd7, 16'd7, 16'd7, 16'd7);
    set_port(1'b1, 16'd8, 16'd8, 16'd8, 16'd8);
    @(negedge clock);
    chk("rst_mid_ready0", req0_ready, 0);
    chk("rst_mid_ready1", req1_ready, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_mid_inflight", inflight, 0);
    chk("rst_mid_ready0_b", req0_ready, 0);
    chk("rst_mid_err_orphan", err_orphan, 0);
    @(posedge clock); #1;
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    issue(1'b1, 16'd60, 16'd61, 16'd0, 16'd0);
    wait_res(got);
    chk("post_rst_res_src", res_src, 1);
    chk("post_rst_res_div0", res_div0, 1);
    drain();
    chk("post_rst_no_orphan", err_orphan, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csi_div_sched.md
Name: csi_div_sched

Overview:
- Shares one complex divider instance (a/b, 16-bit I/Q inputs, 32-bit quotients, strobe-in/strobe-out, no backpressure) between two requesters: channel-estimate ratio (port 0) and pilot-tracking (port 1).
- Arbitrates issue slots round-robin and limits in-flight operations to a credit count.
- Tags each issued operation in an in-order tag FIFO and routes returning quotients to the result bus with the source ID and a divide-by-zero flag.
- Sits between the equalizer front end and the shared divider.

Parameters:
- MAX_INFLIGHT, 8, maximum outstanding divider operations; tag FIFO depth; power of two, 2..16
- CNT_W, 4, width of the in-flight counter; must hold MAX_INFLIGHT

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global enable; when low, no grants and no state change except retirement
- req0_a_i, req0_a_q, req0_b_i, req0_b_q  in  16 each  port-0 operands, signed
- req0_valid  in  1  port-0 request
- req0_ready  out  1  port-0 accept; transfer = valid & ready
- req1_a_i, req1_a_q, req1_b_i, req1_b_q  in  16 each  port-1 operands
- req1_valid  in  1  port-1 request
- req1_ready  out  1  port-1 accept
- div_a_i, div_a_q, div_b_i, div_b_q  out  16 each  operands to divider, registered
- div_strobe  out  1  divider input_strobe, one cycle per operation
- div_p_i, div_p_q  in  32 each  divider quotients
- div_out_strobe  in  1  divider output_strobe
- res_p_i, res_p_q  out  32 each  routed quotients, registered
- res_src  out  1  originating port of the result
- res_div0  out  1  divisor was 0+0j at issue; quotient value is don't-care
- res_valid  out  1  result strobe, one cycle
- inflight  out  CNT_W  current outstanding count
- err_orphan  out  1  sticky: div_out_strobe arrived with tag FIFO empty
- err_overflow  out  1  sticky: count would exceed MAX_INFLIGHT (must never fire)

Behaviour:
- Reset values: all outputs 0; tag FIFO empty; RR pointer = port 0; sticky errors cleared.
- Reset mid-operation discards all in-flight tags. Results returning after reset raise err_orphan; the bench must reset the divider together with this block.
- Ready:
  - reqN_ready = enable & (inflight < MAX_INFLIGHT) & grantN. Ready depends only on registered state.
  - grantN is combinational round-robin.
  - Only port 0 valid: port 0 granted. Only port 1 valid: port 1 granted.
  - Both valid: the port not served last is granted. The RR pointer flips to the other port after each accepted transfer.
  - At most one transfer per cycle; the other ready is 0.
- Issue:
  - A transfer in cycle N drives div_* operands and div_strobe=1 in cycle N+1.
  - div_strobe is 0 in every other cycle; operands hold their last value.
  - In the same cycle N, push tag {src, div0} into the FIFO. div0 = (b_i==0 && b_q==0).
- Retire:
  - div_out_strobe in cycle M pops the FIFO head.
  - In cycle M+1: res_valid=1, res_p_i/res_p_q = div_p_i/div_p_q captured at M, res_src/res_div0 from the head tag.
  - Results are in issue order; the divider has fixed latency and preserves order.
  - Retirement proceeds even when enable=0.
- Counter:
  - inflight += push - pop.
  - Simultaneous push and pop in one cycle leaves it unchanged.
  - A pop in cycle M frees a credit only from cycle M+1; ready at count==MAX stays 0 in cycle M.
- Errors:
  - div_out_strobe with the FIFO empty: no pop, no res_valid, err_orphan=1 until reset.
  - err_overflow is set if a push occurs at count==MAX (design guard only).
- Widths:
  - Operands pass through unchanged.
  - Tag FIFO is MAX_INFLIGHT x 2 bits, with pointers wrapping modulo MAX_INFLIGHT.

Test Plan:
- Bench drives a divider model with fixed latency L=40 and 1-cycle output strobes.
- Single port-0 request a=(1000,-200), b=(50,7) at cycle 10 -> div_strobe at 11 with the same operands; res_valid at 11+L+1 with res_src=0, res_div0=0; inflight 1 then 0.
- Both ports valid continuously for 8 cycles -> grants alternate 0,1,0,1,... starting with port 0 after reset; res_src sequence 0,1,0,1,...; no cycle has two readys.
- Port 0 streams 12 requests back-to-back -> 8 accepted, then ready=0 until the first retirement; accepted count never exceeds 8; err_overflow stays 0.
- Port-1 request with b=(0,0) -> issued normally; result has res_div0=1 and res_src=1.
- Inject div_out_strobe with the FIFO empty -> no res_valid; err_orphan=1 and held.
- Assert reset with 5 operations in flight -> inflight=0 next cycle, all readys 0 during reset; the next request issues normally.
- enable=0 with requests pending and 3 in flight -> no new issues; 3 results still delivered.
